// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline control blocks: forwarding select
// encoding, register-address width and hazard FSM state encoding.
package cpu_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_LDSTALL = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_sys,
    input  logic             rst_b,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: stall/flush enables, registered
// EX forwarding selects and saturating stall/flush performance counters.
//
//   state      | meaning
//   ST_RUN     | normal issue; a load-use hazard here inserts one bubble
//   ST_LDSTALL | bubble cycle; load has moved on to MEM, issue resumes
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              D_Valid,
    input  logic [REG_AW-1:0] D_Rs,
    input  logic [REG_AW-1:0] D_Rt,
    input  logic              D_UsesRs,
    input  logic              D_UsesRt,
    input  logic              D_Wreg,
    input  logic [REG_AW-1:0] D_Rd,
    input  logic              D_IsLoad,
    input  logic              E_BrTaken,
    output logic              PC_En,
    output logic              IFID_En,
    output logic              IFID_Clr,
    output logic              IDEX_Clr,
    output logic [1:0]        FwdA,
    output logic [1:0]        FwdB,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    // Shadow of the instructions now in EX (se_*) and MEM (sm_*). The WB slot
    // is not tracked: the register file writes early, so WB never forwards.
    logic              se_wreg;
    logic              se_load;
    logic [REG_AW-1:0] se_rd;
    logic              sm_wreg;
    logic [REG_AW-1:0] sm_rd;

    state_t state, state_nxt;
    logic   lu;
    logic   pc_en, ifid_en, ifid_clr, idex_clr;
    logic   stall_inc;
    logic [1:0] fwd_a_nxt, fwd_b_nxt;

    assign lu = se_load && se_wreg && D_Valid &&
                ((D_UsesRs && (D_Rs == se_rd)) || (D_UsesRt && (D_Rt == se_rd)));

    always_comb begin
        state_nxt = ST_RUN;
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        stall_inc = 1'b0;
        if (!RSTn) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
        end else if (E_BrTaken) begin
            // Flush wins over a coincident load-use: the dependent op is squashed anyway.
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (lu) begin
                        pc_en     = 1'b0;
                        ifid_en   = 1'b0;
                        idex_clr  = 1'b1;
                        stall_inc = 1'b1;
                        state_nxt = ST_LDSTALL;
                    end
                end
                ST_LDSTALL: state_nxt = ST_RUN;
                default:    state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        fwd_a_nxt = FWD_RF;
        fwd_b_nxt = FWD_RF;
        if (!idex_clr) begin
            if (D_UsesRs && (D_Rs != '0)) begin
                if (se_wreg && (se_rd == D_Rs))      fwd_a_nxt = FWD_MEM;
                else if (sm_wreg && (sm_rd == D_Rs)) fwd_a_nxt = FWD_WB;
            end
            if (D_UsesRt && (D_Rt != '0)) begin
                if (se_wreg && (se_rd == D_Rt))      fwd_b_nxt = FWD_MEM;
                else if (sm_wreg && (sm_rd == D_Rt)) fwd_b_nxt = FWD_WB;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            se_wreg <= 1'b0;
            se_load <= 1'b0;
            se_rd   <= '0;
            sm_wreg <= 1'b0;
            sm_rd   <= '0;
            FwdA    <= FWD_RF;
            FwdB    <= FWD_RF;
        end else begin
            sm_wreg <= se_wreg;
            sm_rd   <= se_rd;
            // r0 is never a real destination, so it is folded into wreg here.
            se_wreg <= !idex_clr && D_Valid && D_Wreg && (D_Rd != '0);
            se_load <= !idex_clr && D_Valid && D_IsLoad;
            se_rd   <= idex_clr ? '0 : D_Rd;
            FwdA    <= fwd_a_nxt;
            FwdB    <= fwd_b_nxt;
        end
    end

    assign PC_En    = pc_en;
    assign IFID_En  = ifid_en;
    assign IFID_Clr = ifid_clr;
    assign IDEX_Clr = idex_clr;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_sys (CLK),
        .rst_b   (RSTn),
        .inc     (stall_inc),
        .cnt     (StallCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_sys (CLK),
        .rst_b   (RSTn),
        .inc     (E_BrTaken),
        .cnt     (FlushCnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard sequences plus random traffic
// against a pipeline-slot reference model. Counters narrowed to reach saturation.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              CLK = 1'b0;
    logic              RSTn;
    logic              D_Valid, D_UsesRs, D_UsesRt, D_Wreg, D_IsLoad, E_BrTaken;
    logic [REG_AW-1:0] D_Rs, D_Rt, D_Rd;
    logic              PC_En, IFID_En, IFID_Clr, IDEX_Clr;
    logic [1:0]        FwdA, FwdB;
    logic [CNT_W-1:0]  StallCnt, FlushCnt;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .D_Valid(D_Valid), .D_Rs(D_Rs), .D_Rt(D_Rt),
        .D_UsesRs(D_UsesRs), .D_UsesRt(D_UsesRt),
        .D_Wreg(D_Wreg), .D_Rd(D_Rd), .D_IsLoad(D_IsLoad),
        .E_BrTaken(E_BrTaken),
        .PC_En(PC_En), .IFID_En(IFID_En), .IFID_Clr(IFID_Clr), .IDEX_Clr(IDEX_Clr),
        .FwdA(FwdA), .FwdB(FwdB), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: destination (0 = none) of the instruction in EX and in MEM.
    int m_ex_rd, m_mem_rd;
    bit m_ex_ld;
    int exp_fa, exp_fb, exp_sc, exp_fc;
    bit last_stall;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int src_sel(input bit uses, input int r);
        if (!uses || r == 0) return 0;
        if (r == m_ex_rd)    return 1;
        if (r == m_mem_rd)   return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_ex_rd = 0; m_mem_rd = 0; m_ex_ld = 0;
        exp_fa = 0; exp_fb = 0; exp_sc = 0; exp_fc = 0;
        last_stall = 0;
    endtask

    // Inputs are already driven (just after a rising edge); check mid-cycle, then advance.
    task automatic step();
        bit lu, stall, br, bubble;
        @(negedge CLK);
        br    = E_BrTaken;
        lu    = m_ex_ld && m_ex_rd != 0 && D_Valid &&
                ((D_UsesRs && int'(D_Rs) == m_ex_rd) || (D_UsesRt && int'(D_Rt) == m_ex_rd));
        stall = lu && !br;
        bubble = stall || br;
        check_eq("pc_en",    PC_En,    br ? 1 : !stall);
        check_eq("ifid_clr", IFID_Clr, br);
        check_eq("idex_clr", IDEX_Clr, bubble);
        if (!br) check_eq("ifid_en", IFID_En, !stall);
        check_eq("fwd_a",     FwdA,     exp_fa);
        check_eq("fwd_b",     FwdB,     exp_fb);
        check_eq("stall_cnt", StallCnt, exp_sc);
        check_eq("flush_cnt", FlushCnt, exp_fc);
        exp_fa   = bubble ? 0 : src_sel(D_UsesRs, int'(D_Rs));
        exp_fb   = bubble ? 0 : src_sel(D_UsesRt, int'(D_Rt));
        m_mem_rd = m_ex_rd;
        m_ex_rd  = (!bubble && D_Valid && D_Wreg) ? int'(D_Rd) : 0;
        m_ex_ld  = !bubble && D_Valid && D_IsLoad;
        if (stall && exp_sc < CMAX) exp_sc++;
        if (br && exp_fc < CMAX)    exp_fc++;
        last_stall = stall;
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input bit w, input int rd, input bit ld, input bit br);
        D_Valid = v; D_Rs = REG_AW'(rs); D_Rt = REG_AW'(rt);
        D_UsesRs = urs; D_UsesRt = urt; D_Wreg = w; D_Rd = REG_AW'(rd);
        D_IsLoad = ld; E_BrTaken = br;
        step();
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pc_en"},    PC_En,    0);
        check_eq({tag, "_ifid_en"},  IFID_En,  0);
        check_eq({tag, "_ifid_clr"}, IFID_Clr, 1);
        check_eq({tag, "_idex_clr"}, IDEX_Clr, 1);
        check_eq({tag, "_fwd_a"},    FwdA,     0);
        check_eq({tag, "_fwd_b"},    FwdB,     0);
        check_eq({tag, "_stall"},    StallCnt, 0);
        check_eq({tag, "_flush"},    FlushCnt, 0);
    endtask

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (!last_stall) begin
                D_Valid  = ($urandom_range(0, 7) != 0);
                D_Rs     = REG_AW'($urandom_range(0, 3));
                D_Rt     = REG_AW'($urandom_range(0, 3));
                D_Rd     = REG_AW'($urandom_range(0, 3));
                D_UsesRs = D_Valid && $urandom_range(0, 3) != 0;
                D_UsesRt = D_Valid && $urandom_range(0, 1) != 0;
                D_Wreg   = D_Valid && $urandom_range(0, 3) != 0;
                D_IsLoad = D_Wreg && $urandom_range(0, 2) == 0;
            end
            E_BrTaken = ($urandom_range(0, 9) == 0);
            step();
        end
    endtask

    initial begin
        RSTn = 1'b0;
        D_Valid = 0; D_Rs = '0; D_Rt = '0; D_UsesRs = 0; D_UsesRt = 0;
        D_Wreg = 0; D_Rd = '0; D_IsLoad = 0; E_BrTaken = 0;
        model_reset();
        #3;
        check_reset_outputs("por");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        // ALU dependency at distance 1, 2 and 3
        issue(1, 1, 2, 1, 1, 1, 3, 0, 0);
        issue(1, 3, 1, 1, 1, 1, 4, 0, 0);
        issue(1, 3, 1, 1, 1, 1, 6, 0, 0);
        issue(1, 3, 3, 1, 1, 1, 7, 0, 0);
        nop();
        issue(1, 1, 2, 1, 1, 1, 3, 0, 0);
        issue(1, 5, 6, 1, 1, 1, 8, 0, 0);
        issue(1, 3, 1, 1, 1, 1, 4, 0, 0);
        nop();
        issue(1, 1, 2, 1, 1, 1, 3, 0, 0);
        issue(1, 5, 6, 1, 1, 1, 8, 0, 0);
        issue(1, 5, 6, 1, 1, 1, 9, 0, 0);
        issue(1, 3, 1, 1, 1, 1, 4, 0, 0);
        nop();

        // Load-use: one bubble, then the reissued add forwards from WB on both operands
        issue(1, 0, 0, 0, 0, 1, 2, 1, 0);
        issue(1, 2, 2, 1, 1, 1, 5, 0, 0);
        issue(1, 2, 2, 1, 1, 1, 5, 0, 0);
        nop();
        nop();
        check_eq("lu_stall_cnt", StallCnt, 1);

        // Branch flush squashes the writer of r7; its consumer must not forward
        issue(1, 1, 1, 1, 0, 1, 6, 0, 0);
        issue(1, 6, 0, 1, 0, 1, 7, 0, 1);
        issue(1, 7, 6, 1, 1, 1, 9, 0, 0);
        nop();
        check_eq("br_flush_cnt", FlushCnt, 1);

        // Load-use coinciding with a flush: flush only
        issue(1, 0, 0, 0, 0, 1, 2, 1, 0);
        issue(1, 2, 2, 1, 1, 1, 5, 0, 1);
        nop();
        check_eq("lu_br_stall_cnt", StallCnt, 1);

        // r0 destination never hazards or forwards
        issue(1, 0, 0, 0, 0, 1, 0, 1, 0);
        issue(1, 0, 0, 1, 1, 1, 5, 0, 0);
        nop();

        random_run(3000);

        // Drive both counters past saturation
        nop();
        for (int i = 0; i < CMAX + 20; i++) begin
            issue(1, 0, 0, 0, 0, 1, 1, 1, 0);
            issue(1, 1, 0, 1, 0, 1, 2, 0, 0);
            issue(1, 1, 0, 1, 0, 1, 2, 0, 0);
        end
        for (int i = 0; i < CMAX + 20; i++) begin
            issue(1, 1, 2, 1, 1, 1, 3, 0, 1);
        end
        nop();
        check_eq("stall_sat", StallCnt, CMAX);
        check_eq("flush_sat", FlushCnt, CMAX);

        // Asynchronous reset mid-cycle with live state
        issue(1, 0, 0, 0, 0, 1, 1, 1, 0);
        D_Valid = 1; D_Rs = 5'd1; D_UsesRs = 1; D_Wreg = 1; D_Rd = 5'd2; D_IsLoad = 0;
        #2;
        RSTn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        random_run(500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB).
- Decides every cycle whether the front end advances, stalls or flushes, and produces registered forwarding selects for the EX-stage operand muxes.
- Keeps a shadow scoreboard of destination registers for the instructions in EX, MEM and WB.
- Counts stall and flush cycles for performance monitoring.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- D_Valid  in  1  ID stage holds a real instruction.
- D_Rs  in  REG_AW  ID source register A.
- D_Rt  in  REG_AW  ID source register B.
- D_UsesRs  in  1  ID instruction reads Rs.
- D_UsesRt  in  1  ID instruction reads Rt.
- D_Wreg  in  1  ID instruction writes a register.
- D_Rd  in  REG_AW  ID destination register.
- D_IsLoad  in  1  ID instruction is a load.
- E_BrTaken  in  1  EX stage resolved a taken branch/jump this cycle.
- PC_En  out  1  PC register load enable.
- IFID_En  out  1  IF/ID register load enable.
- IFID_Clr  out  1  synchronous clear of IF/ID.
- IDEX_Clr  out  1  synchronous clear of ID/EX (bubble).
- FwdA  out  2  EX operand A select: 00 regfile, 01 M_ALUout, 10 W_RegDin.
- FwdB  out  2  EX operand B select, same encoding.
- StallCnt  out  CNT_W  load-use stall cycles.
- FlushCnt  out  CNT_W  branch flush events.

Behaviour:
- Reset (RSTn low, asynchronous): scoreboard valid/wreg/load bits cleared; FwdA=FwdB=00; StallCnt=FlushCnt=0; FSM in RUN.
- Combinational outputs during reset: PC_En=0, IFID_En=0, IFID_Clr=1, IDEX_Clr=1.
- Scoreboard: shadow stages SE, SM, SW, each holding {wreg, rd, isload}. Every clock: SW<=SM, SM<=SE, SE<=ID fields, or a bubble (wreg=0) when IDEX_Clr is asserted. A destination of 0 is treated as wreg=0.
- Load-use hazard (LU): SE.isload and SE.wreg and D_Valid, and either (D_UsesRs and D_Rs==SE.rd) or (D_UsesRt and D_Rt==SE.rd).
- FSM states: RUN and LDSTALL.
  - RUN: LU and not E_BrTaken -> PC_En=0, IFID_En=0, IDEX_Clr=1; go to LDSTALL.
  - LDSTALL: lasts exactly 1 cycle, normal outputs, then return to RUN. A repeated LU there cannot occur, because the load has moved to SM.
- Flush: E_BrTaken=1 in any state -> IFID_Clr=1, IDEX_Clr=1, PC_En=1; next state RUN. Flush overrides a simultaneous LU.
- Normal (no LU, no flush): PC_En=1, IFID_En=1, both clears 0.
- Forwarding select for the instruction entering EX, registered at the clock edge and valid in the following cycle:
  - 01 if the matching producer is in SE (it will be in MEM).
  - else 10 if the producer is in SM (it will be in WB).
  - else 00.
  - Nearer producer wins. Match requires D_UsesRx, wreg=1 and rd!=0.
  - When IDEX_Clr=1, FwdA/FwdB are registered as 00.
- Producers currently in SW need no forwarding: the register file writes in the first half-cycle, so a read returns the new value.
- StallCnt increments on each cycle entering LDSTALL; FlushCnt increments on each E_BrTaken cycle. Both counters saturate at all-ones.
- Latency: stall/flush outputs are combinational in the same cycle; forwarding selects take 1 cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - REG_AW.
  - State encoding ST_RUN, ST_LDSTALL.
- One natural sub-module: sat_counter (CNT_W, inc), instantiated twice.

Test Plan:
- Reset: RSTn=0 mid-run -> PC_En=0, IFID_Clr=1, IDEX_Clr=1, FwdA=FwdB=00 and counters 0 immediately, without waiting for a clock edge.
- ALU dependency: add r3 then sub r4,r3,r1 -> sub in EX with FwdA=01. With one independent instruction between -> FwdA=10. With two between -> 00.
- Load-use: lw r2 then add r5,r2,r2 -> exactly one cycle PC_En=0 and IDEX_Clr=1. Next cycle FwdA=FwdB=10. StallCnt=1.
- Branch flush: E_BrTaken=1 -> IFID_Clr=IDEX_Clr=1 and PC_En=1 for one cycle. FlushCnt=1. No forwarding from the squashed instructions afterward.
- Simultaneous LU and E_BrTaken -> flush only, no LDSTALL entry, StallCnt unchanged.
- r0 destination: lw r0 followed by a use of r0 -> no stall, FwdA=00. Counter saturation: force 2^16 stalls -> StallCnt holds 16'hFFFF.
